// File: rtl/exe_stage_if.sv
// Bundle between ID/EX and EX/MEM around the execute stage.
// The master drives the ID/EX and forwarding inputs; the slave is exe_stage.
interface exe_stage_if #(
    parameter int WIDTH = 32
);
    logic             regwrite_exe;
    logic             memtoreg_exe;
    logic             memwrite_exe;
    logic             alusrc_exe;
    logic             regdst_exe;
    logic [3:0]       alucontrol_exe;
    logic [WIDTH-1:0] data1_exe;
    logic [WIDTH-1:0] data2_exe;
    logic [4:0]       Rt_exe;
    logic [4:0]       Rd_exe;
    logic [WIDTH-1:0] signext_exe;
    logic [WIDTH-1:0] shamt_exe;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic [WIDTH-1:0] result_wb;

    logic [4:0]       writereg_exe;
    logic             stall_exe;
    logic             regwrite_mem;
    logic             memtoreg_mem;
    logic             memwrite_mem;
    logic [WIDTH-1:0] aluout_mem;
    logic [WIDTH-1:0] writedata_mem;
    logic [4:0]       writereg_mem;

    modport master (
        output regwrite_exe, memtoreg_exe, memwrite_exe, alusrc_exe, regdst_exe,
               alucontrol_exe, data1_exe, data2_exe, Rt_exe, Rd_exe,
               signext_exe, shamt_exe, forwardA, forwardB, result_wb,
        input  writereg_exe, stall_exe, regwrite_mem, memtoreg_mem, memwrite_mem,
               aluout_mem, writedata_mem, writereg_mem
    );

    modport slave (
        input  regwrite_exe, memtoreg_exe, memwrite_exe, alusrc_exe, regdst_exe,
               alucontrol_exe, data1_exe, data2_exe, Rt_exe, Rd_exe,
               signext_exe, shamt_exe, forwardA, forwardB, result_wb,
        output writereg_exe, stall_exe, regwrite_mem, memtoreg_mem, memwrite_mem,
               aluout_mem, writedata_mem, writereg_mem
    );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage with forwarding, ALU, iterative shift-add multiplier
// and the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | no multiply in progress; MUL in ID/EX captures operands and stalls
// BUSY  | one shift-add step per cycle, WIDTH steps, stall held
// DONE  | product selected onto the result, EX/MEM loads it, stall released
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_result;
    logic [CW-1:0]    w_shamt;
    logic             w_stall;
    logic             w_start;
    logic [4:0]       w_writereg;

    always_comb begin
        case (bus.forwardA)
            2'b01:   w_src_a = bus.result_wb;
            2'b10:   w_src_a = bus.aluout_mem;
            default: w_src_a = bus.data1_exe;
        endcase
        case (bus.forwardB)
            2'b01:   w_fwd_b = bus.result_wb;
            2'b10:   w_fwd_b = bus.aluout_mem;
            default: w_fwd_b = bus.data2_exe;
        endcase
    end

    assign w_src_b    = bus.alusrc_exe ? bus.signext_exe : w_fwd_b;
    assign w_shamt    = bus.shamt_exe[CW-1:0];
    assign w_writereg = bus.regdst_exe ? bus.Rd_exe : bus.Rt_exe;

    // MUL yields 0 here; the product comes from the accumulator in DONE.
    always_comb begin
        w_alu = '0;
        case (bus.alucontrol_exe)
            OP_AND: w_alu = w_src_a & w_src_b;
            OP_OR:  w_alu = w_src_a | w_src_b;
            OP_ADD: w_alu = w_src_a + w_src_b;
            OP_XOR: w_alu = w_src_a ^ w_src_b;
            OP_SUB: w_alu = w_src_a - w_src_b;
            OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            OP_NOR: w_alu = ~(w_src_a | w_src_b);
            OP_SLL: w_alu = w_fwd_b << w_shamt;
            OP_SRL: w_alu = w_fwd_b >> w_shamt;
            OP_SRA: w_alu = $signed(w_fwd_b) >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.alucontrol_exe == OP_MUL) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_mcand  <= w_src_a;
            r_mplier <= w_src_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign w_result         = (r_state == S_DONE) ? r_acc : w_alu;
    assign bus.writereg_exe = w_writereg;
    // Gated so the hazard unit sees no stall while reset is being applied.
    assign bus.stall_exe    = w_stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.regwrite_mem  <= 1'b0;
            bus.memtoreg_mem  <= 1'b0;
            bus.memwrite_mem  <= 1'b0;
            bus.aluout_mem    <= '0;
            bus.writedata_mem <= '0;
            bus.writereg_mem  <= '0;
        end else begin
            bus.regwrite_mem  <= bus.regwrite_exe & ~w_stall;
            bus.memtoreg_mem  <= bus.memtoreg_exe & ~w_stall;
            bus.memwrite_mem  <= bus.memwrite_exe & ~w_stall;
            bus.aluout_mem    <= w_result;
            bus.writedata_mem <= w_fwd_b;
            bus.writereg_mem  <= w_writereg;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a cycle-level reference model checked every
// cycle, plus literal expectations from hand calculation.
module tb_exe_stage;
    localparam int W = 32;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011;
    localparam logic [3:0] SUB = 4'b0110, SLT = 4'b0111, NOR_ = 4'b1100, SLL = 4'b1000;
    localparam logic [3:0] SRL = 4'b1001, SRA = 4'b1010, MUL = 4'b1011, BAD = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_stage_if #(.WIDTH(W)) bus();
    exe_stage #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] fb,
                                            input int sh);
        case (op)
            AND_: return a & b;
            OR_:  return a | b;
            ADD:  return a + b;
            XOR_: return a ^ b;
            SUB:  return a - b;
            SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            NOR_: return ~(a | b);
            SLL:  return fb << sh;
            SRL:  return fb >> sh;
            SRA:  return 32'(int'(fb) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: m_age counts cycles a MUL has sat in ID/EX.
    logic        e_rw = 0, e_mr = 0, e_mw = 0, e_valid = 1, started = 0;
    logic [31:0] e_alu = 0, e_wd = 0;
    logic [4:0]  e_wr = 0;
    logic [31:0] m_pa = 0, m_pb = 0;
    int          m_age = 0;

    always @(posedge clk) begin
        logic [31:0] a, fb, b;
        started <= 1'b1;
        if (rst) begin
            {e_rw, e_mr, e_mw} <= 3'b000;
            e_alu <= 0; e_wd <= 0; e_wr <= 0; e_valid <= 1'b1; m_age <= 0;
        end else begin
            a  = (bus.forwardA == 2'b01) ? bus.result_wb : (bus.forwardA == 2'b10) ? e_alu : bus.data1_exe;
            fb = (bus.forwardB == 2'b01) ? bus.result_wb : (bus.forwardB == 2'b10) ? e_alu : bus.data2_exe;
            b  = bus.alusrc_exe ? bus.signext_exe : fb;
            if (bus.alucontrol_exe == MUL && m_age <= W) begin
                if (m_age == 0) begin m_pa <= a; m_pb <= b; end
                m_age <= m_age + 1;
                {e_rw, e_mr, e_mw} <= 3'b000;
                e_valid <= 1'b0;
            end else begin
                e_alu <= (bus.alucontrol_exe == MUL) ? m_pa * m_pb
                       : ref_alu(bus.alucontrol_exe, a, b, fb, int'(bus.shamt_exe[4:0]));
                e_wd  <= fb;
                e_wr  <= bus.regdst_exe ? bus.Rd_exe : bus.Rt_exe;
                e_rw  <= bus.regwrite_exe;
                e_mr  <= bus.memtoreg_exe;
                e_mw  <= bus.memwrite_exe;
                e_valid <= 1'b1;
                m_age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stall_exe", 32'(bus.stall_exe), 32'(!rst && bus.alucontrol_exe == MUL && m_age <= W));
            chk("writereg_exe", 32'(bus.writereg_exe), 32'(bus.regdst_exe ? bus.Rd_exe : bus.Rt_exe));
            chk("regwrite_mem", 32'(bus.regwrite_mem), 32'(e_rw));
            chk("memtoreg_mem", 32'(bus.memtoreg_mem), 32'(e_mr));
            chk("memwrite_mem", 32'(bus.memwrite_mem), 32'(e_mw));
            if (e_valid) begin
                chk("aluout_mem", bus.aluout_mem, e_alu);
                chk("writedata_mem", bus.writedata_mem, e_wd);
                chk("writereg_mem", 32'(bus.writereg_mem), 32'(e_wr));
            end
        end
    end

    int   idx = 0;
    logic g_regdst = 1'b1;

    task automatic set_op(input logic [3:0] code, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                          input logic [31:0] imm, input logic [31:0] sh);
        idx++;
        bus.alucontrol_exe = code;
        bus.data1_exe = d1;   bus.data2_exe = d2;
        bus.forwardA = fa;    bus.forwardB = fb;
        bus.alusrc_exe = alusrc;
        bus.signext_exe = imm; bus.shamt_exe = sh;
        bus.regwrite_exe = 1'b1;
        bus.memtoreg_exe = idx[0];
        bus.memwrite_exe = idx[1];
        bus.regdst_exe = g_regdst;
        bus.Rd_exe = 5'(idx);
        bus.Rt_exe = 5'(idx + 16);
    endtask

    task automatic run(input int n, output int stalls);
        stalls = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.stall_exe) stalls++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic op(input logic [3:0] code, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                      input logic [31:0] imm, input logic [31:0] sh, output int stalls);
        set_op(code, d1, d2, fa, fb, alusrc, imm, sh);
        run((code == MUL) ? W + 2 : 1, stalls);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " stall"}, 32'(bus.stall_exe), 32'd0);
        chk({tag, " ctrl"}, 32'({bus.regwrite_mem, bus.memtoreg_mem, bus.memwrite_mem}), 32'd0);
        chk({tag, " aluout"}, bus.aluout_mem, 32'd0);
        chk({tag, " wdata"}, bus.writedata_mem, 32'd0);
        chk({tag, " wreg"}, 32'(bus.writereg_mem), 32'd0);
    endtask

    initial begin
        int s;
        bus.result_wb = 0;
        set_op(ADD, 0, 0, 0, 0, 0, 0, 0);
        run(2, s);
        chk_zero("reset");
        rst = 1'b0;

        op(ADD, 3, 4, 2'b00, 2'b00, 0, 0, 0, s);      chk("add 3+4", bus.aluout_mem, 32'd7);
        op(ADD, 5, 99, 2'b00, 2'b10, 0, 0, 0, s);     chk("add fwd mem", bus.aluout_mem, 32'd12);
        chk("wreg rd", 32'(bus.writereg_mem), 32'(idx));
        g_regdst = 1'b0;
        op(SUB, 3, 5, 0, 0, 0, 0, 0, s);              chk("sub", bus.aluout_mem, 32'hFFFF_FFFE);
        chk("wreg rt", 32'(bus.writereg_mem), 32'(idx + 16));
        g_regdst = 1'b1;
        op(SLT, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, s);  chk("slt signed", bus.aluout_mem, 32'd1);
        op(SLT, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, s);  chk("slt false", bus.aluout_mem, 32'd0);
        op(SRA, 0, 32'h8000_0000, 0, 0, 0, 0, 4, s);  chk("sra", bus.aluout_mem, 32'hF800_0000);
        op(SLL, 0, 1, 0, 0, 0, 0, 31, s);             chk("sll", bus.aluout_mem, 32'h8000_0000);
        op(SRL, 0, 32'h8000_0000, 0, 0, 0, 0, 32'h24, s); chk("srl low shamt", bus.aluout_mem, 32'h0800_0000);
        op(AND_, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, s);   chk("and", bus.aluout_mem, 32'hF000);
        op(OR_, 32'hF0F0, 32'h0F00, 0, 0, 0, 0, 0, s);    chk("or", bus.aluout_mem, 32'hFFF0);
        op(XOR_, 32'hFF, 32'h0F, 0, 0, 0, 0, 0, s);       chk("xor", bus.aluout_mem, 32'hF0);
        op(NOR_, 32'h0, 32'hFFFF_0000, 0, 0, 0, 0, 0, s); chk("nor", bus.aluout_mem, 32'h0000_FFFF);
        op(BAD, 5, 6, 0, 0, 0, 0, 0, s);                  chk("undef op", bus.aluout_mem, 32'd0);
        op(ADD, 10, 77, 0, 0, 1, 32'hFFFF_FFFF, 0, s);    chk("add imm", bus.aluout_mem, 32'd9);
        chk("wdata pre-mux", bus.writedata_mem, 32'd77);
        bus.result_wb = 100;
        op(ADD, 7, 1, 2'b01, 2'b00, 0, 0, 0, s);          chk("fwd wb", bus.aluout_mem, 32'd101);
        op(ADD, 7, 1, 2'b11, 2'b11, 0, 0, 0, s);          chk("fwd 11", bus.aluout_mem, 32'd8);

        op(MUL, 7, 6, 0, 0, 0, 0, 0, s);
        chk("mul 7x6 stall cycles", 32'(s), 32'd33);
        chk("mul 7x6", bus.aluout_mem, 32'd42);
        chk("mul 7x6 regwrite", 32'(bus.regwrite_mem), 32'd1);

        bus.result_wb = 32'hFFFF_FFFD;
        set_op(MUL, 0, 5, 2'b01, 2'b00, 0, 0, 0);
        run(10, s);
        bus.result_wb = 32'd1234;
        run(W + 2 - 10, s);
        chk("mul -3x5", bus.aluout_mem, 32'hFFFF_FFF1);

        set_op(MUL, 9, 9, 0, 0, 0, 0, 0);
        run(10, s);
        rst = 1'b1;
        run(1, s);
        chk_zero("mid-mul reset");
        rst = 1'b0;
        op(ADD, 1, 2, 0, 0, 0, 0, 0, s);
        chk("add after reset", bus.aluout_mem, 32'd3);
        chk("add after reset stall", 32'(s), 32'd0);

        op(MUL, 2, 3, 0, 0, 0, 0, 0, s);
        chk("b2b mul1 stall", 32'(s), 32'd33);
        chk("b2b mul1", bus.aluout_mem, 32'd6);
        op(MUL, 4, 5, 0, 0, 0, 0, 0, s);
        chk("b2b mul2 stall", 32'(s), 32'd33);
        chk("b2b mul2", bus.aluout_mem, 32'd20);
        op(ADD, 1, 1, 0, 0, 0, 0, 0, s);
        chk("after b2b", bus.aluout_mem, 32'd2);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
